// File: rtl/seg7_scan_decoder.sv
// Purpose : rebuilds the 16-bit hex word shown on a scanned, active-low 7-segment display.
// Latency : VALID pulses about STABLE_CYCLES+3 clocks after the fourth digit's pins settle.
// Backpr. : none; a pin observer with no ready input, so every completed frame is published.
//
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset
//   seg_in_i   segment pins, active low (pattern = ~pins), bit6..bit0
//   comm_in_i  digit-select pins, selected digit driven low
//   value_o    last complete decoded word
//   valid_o    one-cycle strobe when value_o updates
//   lock_o     set by a complete frame, cleared by timeout
//   bad_seg_o  one-cycle strobe when a stable digit holds an undecodable pattern
//   capt_o     nibbles captured so far in the frame being assembled
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES  = 64,
   parameter int TIMEOUT_CYCLES = 131072
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [6:0]  seg_in_i,
   input  logic [3:0]  comm_in_i,
   output logic [15:0] value_o,
   output logic        valid_o,
   output logic        lock_o,
   output logic        bad_seg_o,
   output logic [3:0]  capt_o
);

   localparam int SW = $clog2(STABLE_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [SW-1:0] STAB_ACC = SW'(STABLE_CYCLES - 2);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

   // Idle value of the synchronised pair: no digit selected.
   localparam logic [10:0] PAIR_IDLE = {4'b1111, 7'h00};

   logic [10:0]   sync1_q, sync2_q, prev_q;
   logic [SW-1:0] stab_cnt_q, stab_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [15:0]   value_q, value_d;
   logic [3:0]    capt_q, capt_d;
   logic          valid_q, valid_d;
   logic          lock_q, lock_d;
   logic          bad_q, bad_d;

   logic          same;
   logic          comm_ok;
   logic [1:0]    nib_idx;
   logic [6:0]    pat;
   logic          dec_ok;
   logic [3:0]    dec_nib;
   logic          accept;
   logic [3:0]    capt_set;
   logic [15:0]   merged;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= PAIR_IDLE;
         sync2_q <= PAIR_IDLE;
         prev_q  <= PAIR_IDLE;
      end else begin
         sync1_q <= {comm_in_i, seg_in_i};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign same = (sync2_q == prev_q);
   assign pat  = ~sync2_q[6:0];

   // Counter parks at its maximum while the pair holds, so a dwell accepts once.
   always_comb begin
      stab_cnt_d = stab_cnt_q;
      if (!same) begin
         stab_cnt_d = '0;
      end else if (stab_cnt_q != STAB_MAX) begin
         stab_cnt_d = stab_cnt_q + SW'(1);
      end
   end

   always_comb begin
      comm_ok = 1'b1;
      nib_idx = 2'd0;
      case (sync2_q[10:7])
         4'b1110: nib_idx = 2'd0;
         4'b1101: nib_idx = 2'd1;
         4'b1011: nib_idx = 2'd2;
         4'b0111: nib_idx = 2'd3;
         default: comm_ok = 1'b0;
      endcase
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_nib = 4'h0;
      case (pat)
         7'h3F: dec_nib = 4'h0;
         7'h30: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h79: dec_nib = 4'h3;
         7'h74: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h6F: dec_nib = 4'h6;
         7'h38: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h7C: dec_nib = 4'h9;
         7'h7E: dec_nib = 4'hA;
         7'h67: dec_nib = 4'hB;
         7'h0F: dec_nib = 4'hC;
         7'h73: dec_nib = 4'hD;
         7'h4F: dec_nib = 4'hE;
         7'h4E: dec_nib = 4'hF;
         default: dec_ok = 1'b0;
      endcase
   end

   // Accept on the edge where the dwell count reaches STABLE_CYCLES-1.
   assign accept   = same && (stab_cnt_q == STAB_ACC) && comm_ok;
   assign capt_set = capt_q | (4'b0001 << nib_idx);

   always_comb begin
      merged                     = shadow_q;
      merged[{nib_idx, 2'b00} +: 4] = dec_nib;
   end

   always_comb begin
      shadow_d = shadow_q;
      capt_d   = capt_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      lock_d   = lock_q;
      bad_d    = 1'b0;
      to_cnt_d = to_cnt_q;
      if (accept) begin
         to_cnt_d = '0;
         if (dec_ok) begin
            shadow_d = merged;
            if (capt_set == 4'b1111) begin
               value_d = merged;
               valid_d = 1'b1;
               capt_d  = 4'b0000;
               lock_d  = 1'b1;
            end else begin
               capt_d = capt_set;
            end
         end else begin
            bad_d  = 1'b1;
            capt_d = capt_q & ~(4'b0001 << nib_idx);
         end
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_d = to_cnt_q + TW'(1);
         // Abandon the partial frame once, when the count first reaches its limit.
         if (to_cnt_q == TO_FIRE) begin
            capt_d = 4'b0000;
            lock_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stab_cnt_q <= '0;
         to_cnt_q   <= '0;
         shadow_q   <= 16'h0000;
         value_q    <= 16'h0000;
         capt_q     <= 4'b0000;
         valid_q    <= 1'b0;
         lock_q     <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         stab_cnt_q <= stab_cnt_d;
         to_cnt_q   <= to_cnt_d;
         shadow_q   <= shadow_d;
         value_q    <= value_d;
         capt_q     <= capt_d;
         valid_q    <= valid_d;
         lock_q     <= lock_d;
         bad_q      <= bad_d;
      end
   end

   assign value_o   = value_q;
   assign valid_o   = valid_q;
   assign lock_o    = lock_q;
   assign bad_seg_o = bad_q;
   assign capt_o    = capt_q;

endmodule
